// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver
// Purpose  : Time-multiplexed driver for a three-digit common-anode/cathode
//            seven-segment display. A BCD value is captured on a load strobe
//            into a pending register. It is moved into the display register
//            only at a frame boundary, so a frame never shows a mix of old
//            and new digits. Each digit slot lasts CLK_DIV cycles. The first
//            cycle of every slot is dead time with all outputs off, which
//            avoids ghosting while the enables switch. Leading-zero blanking
//            is optional.
//
// Ports    : clk        in   1  system clock
//            reset      in   1  synchronous active-high reset
//            load       in   1  one-cycle strobe, samples hundreds/tens/ones
//            hundreds   in   4  BCD hundreds digit
//            tens       in   4  BCD tens digit
//            ones       in   4  BCD ones digit
//            blank_en   in   1  leading-zero blanking enable (live, no load)
//            seg        out  7  segments {g,f,e,d,c,b,a}, registered
//            an         out  3  digit enables {hundreds,tens,ones}, registered
//            frame_tick out  1  one-cycle pulse after a pending value is
//                               transferred to the display register
//
// Params   : CLK_DIV    clk cycles per digit slot (>= 2)
//            ACTIVE_LOW 1 = seg/an inverted at the pins (0 = lit/enabled)
//
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_scan_driver #(
    parameter int CLK_DIV    = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_en,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ZERO = '0;

    // Slot state encoding
    localparam logic [1:0] c_SLOT_ONES     = 2'd0;
    localparam logic [1:0] c_SLOT_TENS     = 2'd1;
    localparam logic [1:0] c_SLOT_HUNDREDS = 2'd2;

    // Pin-level "all off" patterns after polarity is applied
    localparam logic [6:0] c_SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0] c_AN_OFF  = ACTIVE_LOW ? 3'h7  : 3'h0;

    // ------------------------------------------------------------------------
    // Active-high segment decode; non-BCD codes show a dash so a corrupted
    // digit is visible rather than silently rendered as a number.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] digit);
        logic [6:0] v_seg;
        case (digit)
            4'd0:    v_seg = 7'h3F;
            4'd1:    v_seg = 7'h06;
            4'd2:    v_seg = 7'h5B;
            4'd3:    v_seg = 7'h4F;
            4'd4:    v_seg = 7'h66;
            4'd5:    v_seg = 7'h6D;
            4'd6:    v_seg = 7'h7D;
            4'd7:    v_seg = 7'h07;
            4'd8:    v_seg = 7'h7F;
            4'd9:    v_seg = 7'h6F;
            default: v_seg = 7'h40;
        endcase
        return v_seg;
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div;
    logic               w_div_last;
    logic               w_div_zero;

    logic [1:0]         r_slot;
    logic [1:0]         w_slot_next;

    logic               w_frame_boundary;
    logic               w_transfer;

    logic [3:0]         r_pend_h;
    logic [3:0]         r_pend_t;
    logic [3:0]         r_pend_o;
    logic               r_pend_valid;

    logic [3:0]         r_disp_h;
    logic [3:0]         r_disp_t;
    logic [3:0]         r_disp_o;

    logic               r_frame_tick;

    logic [2:0]         w_slot_an;
    logic [3:0]         w_slot_digit;
    logic               w_slot_blank;
    logic               w_lit;
    logic [6:0]         w_seg_raw;
    logic [2:0]         w_an_raw;

    logic [6:0]         r_seg;
    logic [2:0]         r_an;

    // ------------------------------------------------------------------------
    // Slot divider: counts 0..CLK_DIV-1 and wraps
    // ------------------------------------------------------------------------
    assign w_div_last = (r_div == c_DIV_LAST);
    assign w_div_zero = (r_div == c_DIV_ZERO);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= c_DIV_ZERO;
        end else if (w_div_last) begin
            r_div <= c_DIV_ZERO;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Slot FSM -- state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot <= c_SLOT_ONES;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    // ------------------------------------------------------------------------
    // Slot FSM -- next state. The unused encoding falls back to ONES.
    // ------------------------------------------------------------------------
    always_comb begin
        w_slot_next = r_slot;
        if (w_div_last) begin
            case (r_slot)
                c_SLOT_ONES:     w_slot_next = c_SLOT_TENS;
                c_SLOT_TENS:     w_slot_next = c_SLOT_HUNDREDS;
                default:         w_slot_next = c_SLOT_ONES;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Slot FSM -- outputs: enable bit, digit to show, and leading-zero blank
    // for the current slot. blank_en is used live so it takes effect without
    // a reload.
    // ------------------------------------------------------------------------
    always_comb begin
        w_slot_an    = 3'b000;
        w_slot_digit = r_disp_o;
        w_slot_blank = 1'b0;
        case (r_slot)
            c_SLOT_ONES: begin
                w_slot_an    = 3'b001;
                w_slot_digit = r_disp_o;
            end
            c_SLOT_TENS: begin
                w_slot_an    = 3'b010;
                w_slot_digit = r_disp_t;
                w_slot_blank = blank_en && (r_disp_h == 4'd0) && (r_disp_t == 4'd0);
            end
            c_SLOT_HUNDREDS: begin
                w_slot_an    = 3'b100;
                w_slot_digit = r_disp_h;
                w_slot_blank = blank_en && (r_disp_h == 4'd0);
            end
            default: begin
                w_slot_an    = 3'b000;
                w_slot_digit = r_disp_o;
                w_slot_blank = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame boundary: last divider cycle of the hundreds slot. The display
    // register only changes here, so a frame is always self-consistent.
    // ------------------------------------------------------------------------
    assign w_frame_boundary = w_div_last && (r_slot == c_SLOT_HUNDREDS);
    assign w_transfer       = w_frame_boundary && r_pend_valid;

    // ------------------------------------------------------------------------
    // Pending / display registers. A load on the boundary cycle lands in
    // pending while the older pending value moves to display; the flag stays
    // set so the new value is picked up at the following boundary.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_h     <= 4'd0;
            r_pend_t     <= 4'd0;
            r_pend_o     <= 4'd0;
            r_pend_valid <= 1'b0;
            r_disp_h     <= 4'd0;
            r_disp_t     <= 4'd0;
            r_disp_o     <= 4'd0;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_disp_h <= r_pend_h;
                r_disp_t <= r_pend_t;
                r_disp_o <= r_pend_o;
            end

            if (load) begin
                r_pend_h     <= hundreds;
                r_pend_t     <= tens;
                r_pend_o     <= ones;
                r_pend_valid <= 1'b1;
            end else if (w_frame_boundary) begin
                r_pend_valid <= 1'b0;
            end

            r_frame_tick <= w_transfer;
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: everything dark during dead time, blanked slots, and
    // reset; polarity is applied just before the output flops.
    // ------------------------------------------------------------------------
    assign w_lit     = !w_div_zero && !w_slot_blank && (w_slot_an != 3'b000);
    assign w_seg_raw = w_lit ? f_decode(w_slot_digit) : 7'h00;
    assign w_an_raw  = w_lit ? w_slot_an : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= c_SEG_OFF;
            r_an  <= c_AN_OFF;
        end else begin
            r_seg <= w_seg_raw ^ {7{ACTIVE_LOW}};
            r_an  <= w_an_raw ^ {3{ACTIVE_LOW}};
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_driver
// Purpose  : Self-checking bench for seven_seg_scan_driver. Two instances
//            (active-high and active-low) share the same stimulus. A
//            behavioural model predicts every cycle's outputs from a cycle
//            count since reset; a table of hand-decoded frames, a few
//            directed multi-cycle sequences and a random phase follow.
// Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 3 * CLK_DIV;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_en;

    logic [6:0] seg_ah;
    logic [2:0] an_ah;
    logic       ft_ah;
    logic [6:0] seg_al;
    logic [2:0] an_al;
    logic       ft_al;

    seven_seg_scan_driver #(.CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .blank_en   (blank_en),
        .seg        (seg_ah),
        .an         (an_ah),
        .frame_tick (ft_ah)
    );

    seven_seg_scan_driver #(.CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .blank_en   (blank_en),
        .seg        (seg_al),
        .an         (an_al),
        .frame_tick (ft_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int ticks_seen = 0;

    // ---------------- behavioural model state ----------------
    int         m_t;          // cycles since reset released
    logic [3:0] m_pend [3];   // index 0 = ones, 1 = tens, 2 = hundreds
    logic [3:0] m_disp [3];
    bit         m_pv;
    bit         m_xfer;
    int         m_last_phase;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: predict, clock, update model, compare both instances.
    task automatic tick();
        logic [6:0] e_seg;
        logic [2:0] e_an;
        logic       e_tick;
        logic [6:0] e_seg_n;
        logic [2:0] e_an_n;
        int         div;
        int         slot;
        bit         blank;
        bit         bnd;
        bnd = 1'b0;
        if (reset) begin
            e_seg  = 7'h00;
            e_an   = 3'b000;
            e_tick = 1'b0;
        end else begin
            div   = m_t % CLK_DIV;
            slot  = (m_t / CLK_DIV) % 3;
            blank = blank_en && ((slot == 2 && m_disp[2] == 4'd0) ||
                                 (slot == 1 && m_disp[2] == 4'd0 && m_disp[1] == 4'd0));
            if (div == 0 || blank) begin
                e_seg = 7'h00;
                e_an  = 3'b000;
            end else begin
                e_seg = seg_lut(m_disp[slot]);
                e_an  = 3'(1 << slot);
            end
            bnd    = (m_t % FRAME) == FRAME - 1;
            e_tick = bnd && m_pv;
        end
        m_last_phase = reset ? -1 : (m_t % FRAME);

        @(posedge clk);

        if (reset) begin
            m_t    = 0;
            m_pv   = 1'b0;
            m_xfer = 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_pend[k] = 4'd0;
                m_disp[k] = 4'd0;
            end
        end else begin
            m_xfer = bnd && m_pv;
            if (m_xfer) m_disp = m_pend;
            if (load) begin
                m_pend[0] = ones;
                m_pend[1] = tens;
                m_pend[2] = hundreds;
                m_pv      = 1'b1;
            end else if (bnd) begin
                m_pv = 1'b0;
            end
            m_t++;
        end

        #1;
        e_seg_n = ~e_seg;
        e_an_n  = ~e_an;
        chk("seg_ah", 32'(seg_ah), 32'(e_seg));
        chk("an_ah",  32'(an_ah),  32'(e_an));
        chk("tick_ah", 32'(ft_ah), 32'(e_tick));
        chk("seg_al", 32'(seg_al), 32'(e_seg_n));
        chk("an_al",  32'(an_al),  32'(e_an_n));
        chk("tick_al", 32'(ft_al), 32'(e_tick));
        if (ft_ah) ticks_seen++;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int k = 0; k < cycles; k++) tick();
        reset = 1'b0;
    endtask

    task automatic wait_xfer(input string name);
        int waited;
        waited = 0;
        while (!m_xfer && waited < 4 * FRAME) begin
            tick();
            waited++;
        end
        if (!m_xfer) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no frame transfer within %0d cycles", name, 4 * FRAME);
        end
    endtask

    task automatic advance_to_phase(input int ph);
        int waited;
        waited = 0;
        while ((m_t % FRAME) != ph && waited < 2 * FRAME) begin
            tick();
            waited++;
        end
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 2) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    // ---------------- table of hand-decoded frames ----------------
    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       blank;
        logic [6:0] s_o;
        logic [2:0] a_o;
        logic [6:0] s_t;
        logic [2:0] a_t;
        logic [6:0] s_h;
        logic [2:0] a_h;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        logic [6:0] inv_s;
        logic [2:0] inv_a;

        vecs[0] = '{4'h2, 4'h5, 4'h5, 1'b0, 7'h6D, 3'b001, 7'h6D, 3'b010, 7'h5B, 3'b100};
        vecs[1] = '{4'h0, 4'h0, 4'h7, 1'b1, 7'h07, 3'b001, 7'h00, 3'b000, 7'h00, 3'b000};
        vecs[2] = '{4'h0, 4'h0, 4'h0, 1'b1, 7'h3F, 3'b001, 7'h00, 3'b000, 7'h00, 3'b000};
        vecs[3] = '{4'hC, 4'h1, 4'h2, 1'b0, 7'h5B, 3'b001, 7'h06, 3'b010, 7'h40, 3'b100};
        vecs[4] = '{4'h0, 4'h4, 4'h0, 1'b1, 7'h3F, 3'b001, 7'h66, 3'b010, 7'h00, 3'b000};
        vecs[5] = '{4'h0, 4'h0, 4'h0, 1'b0, 7'h3F, 3'b001, 7'h3F, 3'b010, 7'h3F, 3'b100};
        vecs[6] = '{4'hF, 4'hA, 4'h9, 1'b1, 7'h6F, 3'b001, 7'h40, 3'b010, 7'h40, 3'b100};
        vecs[7] = '{4'h8, 4'h0, 4'h3, 1'b1, 7'h4F, 3'b001, 7'h3F, 3'b010, 7'h7F, 3'b100};
        vecs[8] = '{4'h1, 4'h6, 4'h4, 1'b0, 7'h66, 3'b001, 7'h7D, 3'b010, 7'h06, 3'b100};

        m_t = 0; m_pv = 1'b0; m_xfer = 1'b0; m_last_phase = -1;
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 4'd0;
            m_disp[k] = 4'd0;
        end
        reset = 1'b1; load = 1'b0; blank_en = 1'b0;
        hundreds = 4'd0; tens = 4'd0; ones = 4'd0;

        // Reset state, including a load ignored during reset
        load = 1'b1; hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
        do_reset(3);
        load = 1'b0;
        chk("reset_seg_ah", 32'(seg_ah), 32'h00);
        chk("reset_an_al",  32'(an_al),  32'h7);

        // Table: load, wait for transfer, check dead/ones/tens/hundreds slots
        for (int i = 0; i < NV; i++) begin
            hundreds = vecs[i].h; tens = vecs[i].t; ones = vecs[i].o;
            blank_en = vecs[i].blank;
            load = 1'b1;
            tick();
            load = 1'b0;
            wait_xfer($sformatf("tbl%0d_xfer", i));
            for (int k = 0; k < FRAME; k++) begin
                tick();
                case (m_last_phase)
                    0: begin
                        chk($sformatf("tbl%0d_dead_seg", i), 32'(seg_ah), 32'h00);
                        chk($sformatf("tbl%0d_dead_an", i),  32'(an_ah),  32'h0);
                    end
                    2: begin
                        inv_s = ~vecs[i].s_o; inv_a = ~vecs[i].a_o;
                        chk($sformatf("tbl%0d_ones_seg", i), 32'(seg_ah), 32'(vecs[i].s_o));
                        chk($sformatf("tbl%0d_ones_an", i),  32'(an_ah),  32'(vecs[i].a_o));
                        chk($sformatf("tbl%0d_ones_seg_al", i), 32'(seg_al), 32'(inv_s));
                        chk($sformatf("tbl%0d_ones_an_al", i),  32'(an_al),  32'(inv_a));
                    end
                    6: begin
                        inv_s = ~vecs[i].s_t; inv_a = ~vecs[i].a_t;
                        chk($sformatf("tbl%0d_tens_seg", i), 32'(seg_ah), 32'(vecs[i].s_t));
                        chk($sformatf("tbl%0d_tens_an", i),  32'(an_ah),  32'(vecs[i].a_t));
                        chk($sformatf("tbl%0d_tens_seg_al", i), 32'(seg_al), 32'(inv_s));
                        chk($sformatf("tbl%0d_tens_an_al", i),  32'(an_al),  32'(inv_a));
                    end
                    10: begin
                        inv_s = ~vecs[i].s_h; inv_a = ~vecs[i].a_h;
                        chk($sformatf("tbl%0d_hund_seg", i), 32'(seg_ah), 32'(vecs[i].s_h));
                        chk($sformatf("tbl%0d_hund_an", i),  32'(an_ah),  32'(vecs[i].a_h));
                        chk($sformatf("tbl%0d_hund_seg_al", i), 32'(seg_al), 32'(inv_s));
                        chk($sformatf("tbl%0d_hund_an_al", i),  32'(an_al),  32'(inv_a));
                    end
                    default: ;
                endcase
            end
        end

        // Overwrite before the boundary: only 4/5/6 ever shown, one tick
        blank_en = 1'b0;
        do_reset(2);
        ticks_seen = 0;
        hundreds = 4'd1; tens = 4'd2; ones = 4'd3; load = 1'b1; tick(); load = 1'b0;
        tick();
        hundreds = 4'd4; tens = 4'd5; ones = 4'd6; load = 1'b1; tick(); load = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (m_last_phase == 2 && m_t > FRAME)
                chk("ovr_ones_seg", 32'(seg_ah), 32'h7D);
        end
        chk("ovr_tick_count", 32'(ticks_seen), 32'd1);

        // Load exactly on the boundary while 1/1/1 is pending
        do_reset(2);
        ticks_seen = 0;
        hundreds = 4'd1; tens = 4'd1; ones = 4'd1; load = 1'b1; tick(); load = 1'b0;
        advance_to_phase(FRAME - 1);
        hundreds = 4'd9; tens = 4'd9; ones = 4'd9; load = 1'b1; tick(); load = 1'b0;
        chk("bnd_first_xfer", 32'(m_xfer), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (m_last_phase == 2) chk("bnd_frame1_ones", 32'(seg_ah), 32'h06);
        end
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (m_last_phase == 6) chk("bnd_frame2_tens", 32'(seg_ah), 32'h6F);
        end
        chk("bnd_tick_count", 32'(ticks_seen), 32'd2);

        // Dash in hundreds, then reset mid-frame with a load pending
        do_reset(1);
        hundreds = 4'hC; tens = 4'd3; ones = 4'd8; load = 1'b1; tick(); load = 1'b0;
        wait_xfer("dash_xfer");
        advance_to_phase(10);
        tick();
        chk("dash_hund_seg", 32'(seg_ah), 32'h40);
        hundreds = 4'd7; tens = 4'd7; ones = 4'd7; load = 1'b1; tick(); load = 1'b0;
        tick();
        reset = 1'b1; load = 1'b1; tick(); load = 1'b0; tick(); reset = 1'b0;
        chk("rst_mid_seg_off", 32'(seg_ah), 32'h00);
        chk("rst_mid_an_off_al", 32'(an_al), 32'h7);
        ticks_seen = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            if (m_last_phase == 10) chk("rst_mid_hund_zero", 32'(seg_ah), 32'h3F);
        end
        chk("rst_mid_no_tick", 32'(ticks_seen), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 7) == 0);
            if (!reset && (m_t % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1) load = 1'b1;
            if ($urandom_range(0, 15) == 0) blank_en = ~blank_en;
            hundreds = rand_digit();
            tens     = rand_digit();
            ones     = rand_digit();
            tick();
        end
        reset = 1'b0;
        load  = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter CLK_DIV, default 50000: clk cycles per digit slot; legal range >= 2.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, seg and an are inverted at the output (0 = lit/enabled).
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 load  input  1  one-cycle strobe; samples hundreds/tens/ones.
REQ-007 hundreds  input  4  BCD hundreds digit from the binary-to-BCD converter.
REQ-008 tens  input  4  BCD tens digit.
REQ-009 ones  input  4  BCD ones digit.
REQ-010 blank_en  input  1  enables leading-zero blanking.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, seg[0]=a; registered.
REQ-012 an  output  3  digit enables, an[0]=ones, an[1]=tens, an[2]=hundreds; registered.
REQ-013 frame_tick  output  1  one-cycle pulse when a pending value is transferred to the display register.

Function
REQ-014 Load SHALL capture {hundreds,tens,ones} into a pending register and set a pending flag; a later load before transfer SHALL overwrite the pending value.
REQ-015 The display register SHALL be updated only at a frame boundary: the divider is at CLK_DIV-1 and the slot is HUNDREDS. If the pending flag is set, pending SHALL copy to display, the flag SHALL clear, and frame_tick SHALL pulse in the next cycle.
REQ-016 If load coincides with a frame boundary, the display SHALL take the previous pending value (if any), the new inputs SHALL go to pending, and the pending flag SHALL remain set.
REQ-017 The divider SHALL count 0..CLK_DIV-1 and wrap to 0; at CLK_DIV-1 the slot state SHALL advance ONES -> TENS -> HUNDREDS -> ONES.
REQ-018 seg and an SHALL be registered and reflect the slot/divider values of the previous cycle (1-cycle latency).
REQ-019 Dead time: while the divider equals 0, all an SHALL be inactive and all seg SHALL be off.
REQ-020 Otherwise the an bit of the current slot SHALL be active, other an bits inactive, and seg SHALL be the decode of that slot's display digit.
REQ-021 Active-high decode: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; 10..15 SHALL display a dash (0x40).
REQ-022 With blank_en=1: hundreds SHALL blank when it equals 0; tens SHALL blank when hundreds=0 and tens=0; ones SHALL never blank. A blanked slot SHALL have all an inactive and seg off.
REQ-023 blank_en SHALL be evaluated combinationally each cycle and need no load.
REQ-024 A complete frame SHALL take exactly 3*CLK_DIV cycles.

Reset
REQ-025 While reset=1: divider=0, slot=ONES, display and pending registers=0, pending flag=0, frame_tick=0, all an inactive, all seg off (after ACTIVE_LOW polarity).
REQ-026 Reset asserted mid-frame or with a load pending SHALL discard the pending value; a load in the same cycle as reset SHALL be ignored.
REQ-027 In the first cycle after reset deasserts, the divider SHALL be 0 and the slot ONES, so scanning resumes with dead time.

Verification (CLK_DIV=4, ACTIVE_LOW=0)
REQ-028 Load 2/5/5 after reset, blank_en=0 -> after the first frame boundary, frame_tick pulses once; the next frame shows an=001 with seg=0x6D, then an=010 with seg=0x6D, then an=100 with seg=0x5B, each for 3 cycles after 1 dead cycle.
REQ-029 Display 0/0/7 with blank_en=1 -> hundreds and tens slots give an=000 and seg=0x00; ones slot gives an=001 and seg=0x07. With 0/0/0, only ones is lit, with seg=0x3F.
REQ-030 Load 1/2/3, then load 4/5/6 two cycles later, before the boundary -> only 4/5/6 is ever displayed, and frame_tick pulses once.
REQ-031 Load 9/9/9 exactly at the boundary while 1/1/1 is pending -> 1/1/1 is displayed for one frame, then 9/9/9, with two frame_tick pulses.
REQ-032 Hundreds=0xC -> dash 0x40 in the hundreds slot. Then reset mid-frame with a load pending -> outputs off, display 0/0/0 after reset, and no frame_tick.
REQ-033 ACTIVE_LOW=1 rerun of REQ-028 -> an and seg are the bitwise inverse of the values above.
